// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the request, ALU and result signals of alu_issue_ctrl.
// The slave modport is the issue controller's view. The master modport
// is the surrounding system: the requester, the external ALU and the
// result consumer.
interface alu_issue_ctrl_if #(
    parameter int DW = 32,
    parameter int GW = 4
);
    // request handshake and decoded instruction fields
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_opcode;
    logic [5:0]    req_funct;
    logic [4:0]    req_rt;
    logic [15:0]   req_imm;
    logic [DW-1:0] req_rs_val;
    logic [DW-1:0] req_rt_val;

    // external ALU
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [GW-1:0] alu_gin;
    logic [DW-1:0] alu_sum;
    logic          alu_zout;

    // result handshake
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          res_zero;
    logic          res_branch;
    logic          res_illegal;

    modport master (
        output req_valid, req_opcode, req_funct, req_rt, req_imm,
               req_rs_val, req_rt_val,
        input  req_ready,
        input  alu_a, alu_b, alu_gin,
        output alu_sum, alu_zout,
        input  res_valid, res_data, res_zero, res_branch, res_illegal,
        output res_ready
    );

    modport slave (
        input  req_valid, req_opcode, req_funct, req_rt, req_imm,
               req_rs_val, req_rt_val,
        output req_ready,
        output alu_a, alu_b, alu_gin,
        input  alu_sum, alu_zout,
        output res_valid, res_data, res_zero, res_branch, res_illegal,
        input  res_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded MIPS-lite instruction to an external
// 32-bit ALU. It decodes the control-line code and the b operand, drives
// registered a/b/gin for one cycle and captures sum/zout into a held result.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN. When it is defined, an
// unsupported encoding bypasses the ALU and is reported with res_illegal.
// When it is undefined, the encoding runs as add with b = rt_val.
module alu_issue_ctrl #(
    parameter int DW = 32,
    parameter int GW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_issue_ctrl_if.slave   bus
);

    // ALU control-line codes
    localparam logic [GW-1:0] G_ADD  = GW'(4'b0000);
    localparam logic [GW-1:0] G_SUB  = GW'(4'b0010);
    localparam logic [GW-1:0] G_AND  = GW'(4'b1000);
    localparam logic [GW-1:0] G_OR   = GW'(4'b0100);
    localparam logic [GW-1:0] G_NOR  = GW'(4'b1001);
    localparam logic [GW-1:0] G_SLT  = GW'(4'b0001);
    localparam logic [GW-1:0] G_BNE  = GW'(4'b1010);
    localparam logic [GW-1:0] G_BLEZ = GW'(4'b1101);
    localparam logic [GW-1:0] G_BGTZ = GW'(4'b1100);
    localparam logic [GW-1:0] G_BGEZ = GW'(4'b1011);
    localparam logic [GW-1:0] G_BLTZ = GW'(4'b1110);

    typedef enum logic [1:0] {
        B_RT = 2'd0,
        B_SE = 2'd1,
        B_ZE = 2'd2
    } bsel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [GW-1:0] alu_gin_q, alu_gin_d;
    logic          is_branch_q, is_branch_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_zero_q, res_zero_d;
    logic          res_branch_q, res_branch_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic          res_illegal_q, res_illegal_d;
`endif

    logic          dec_legal;
    logic [GW-1:0] dec_gin;
    bsel_t         dec_bsel;
    logic          dec_branch;
    logic [DW-1:0] dec_b;
    logic [DW-1:0] imm_se;
    logic [DW-1:0] imm_ze;

    // Immediate extension: the low 16 bits come straight from imm. The upper
    // bits replicate imm[15] (sign) or are zero.
    for (genvar gi = 0; gi < DW; gi++) begin : g_ext
        if (gi < 16) begin : g_low
            assign imm_se[gi] = bus.req_imm[gi];
            assign imm_ze[gi] = bus.req_imm[gi];
        end else begin : g_high
            assign imm_se[gi] = bus.req_imm[15];
            assign imm_ze[gi] = 1'b0;
        end
    end

    // Instruction decode: control code, b-operand source and branch flag
    always_comb begin
        dec_legal  = 1'b1;
        dec_gin    = G_ADD;
        dec_bsel   = B_RT;
        dec_branch = 1'b0;
        case (bus.req_opcode)
            6'b000000: begin
                case (bus.req_funct)
                    6'b100000: dec_gin = G_ADD;
                    6'b100010: dec_gin = G_SUB;
                    6'b100100: dec_gin = G_AND;
                    6'b100101: dec_gin = G_OR;
                    6'b100111: dec_gin = G_NOR;
                    6'b101010: dec_gin = G_SLT;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001000: begin dec_gin = G_ADD; dec_bsel = B_SE; end  // addi
            6'b001010: begin dec_gin = G_SLT; dec_bsel = B_SE; end  // slti
            6'b100011: begin dec_gin = G_ADD; dec_bsel = B_SE; end  // lw
            6'b101011: begin dec_gin = G_ADD; dec_bsel = B_SE; end  // sw
            6'b001100: begin dec_gin = G_AND; dec_bsel = B_ZE; end  // andi
            6'b001101: begin dec_gin = G_OR;  dec_bsel = B_ZE; end  // ori
            6'b000100: begin dec_gin = G_SUB;  dec_branch = 1'b1; end  // beq
            6'b000101: begin dec_gin = G_BNE;  dec_branch = 1'b1; end  // bne
            6'b000110: begin dec_gin = G_BLEZ; dec_branch = 1'b1; end  // blez
            6'b000111: begin dec_gin = G_BGTZ; dec_branch = 1'b1; end  // bgtz
            6'b000001: begin
                case (bus.req_rt)
                    5'b00001: begin dec_gin = G_BGEZ; dec_branch = 1'b1; end
                    5'b00000: begin dec_gin = G_BLTZ; dec_branch = 1'b1; end
                    default:  dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
        // An unsupported encoding collapses to a plain add on rt_val, so
        // alu_gin never carries a code outside the table.
        if (!dec_legal) begin
            dec_gin    = G_ADD;
            dec_bsel   = B_RT;
            dec_branch = 1'b0;
        end
    end

    // b operand mux
    always_comb begin
        dec_b = bus.req_rt_val;
        case (dec_bsel)
            B_SE:    dec_b = imm_se;
            B_ZE:    dec_b = imm_ze;
            default: dec_b = bus.req_rt_val;
        endcase
    end

    // Next-state and datapath update for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_gin_d    = alu_gin_q;
        is_branch_d  = is_branch_q;
        res_data_d   = res_data_q;
        res_zero_d   = res_zero_q;
        res_branch_d = res_branch_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
        res_illegal_d = res_illegal_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
                    // Illegal requests bypass the ALU. The ALU drive keeps its
                    // old value and the result is reported on the next cycle.
                    if (!dec_legal) begin
                        res_data_d    = '0;
                        res_zero_d    = 1'b0;
                        res_branch_d  = 1'b0;
                        res_illegal_d = 1'b1;
                        state_d       = RESP;
                    end else
`endif
                    begin
                        alu_a_d     = bus.req_rs_val;
                        alu_b_d     = dec_b;
                        alu_gin_d   = dec_gin;
                        is_branch_d = dec_branch;
                        state_d     = EXEC;
                    end
                end
            end
            EXEC: begin
                // The ALU has had a full cycle of stable operands, so capture it.
                res_data_d   = bus.alu_sum;
                res_zero_d   = bus.alu_zout;
                res_branch_d = is_branch_q & bus.alu_zout;
`ifdef ALU_ISSUE_ILLEGAL_EN
                res_illegal_d = 1'b0;
`endif
                state_d      = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_gin_q    <= '0;
            is_branch_q  <= 1'b0;
            res_data_q   <= '0;
            res_zero_q   <= 1'b0;
            res_branch_q <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            res_illegal_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_gin_q    <= alu_gin_d;
            is_branch_q  <= is_branch_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            res_branch_q <= res_branch_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
            res_illegal_q <= res_illegal_d;
`endif
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.res_valid  = (state_q == RESP);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_gin    = alu_gin_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_zero   = res_zero_q;
    assign bus.res_branch = res_branch_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign bus.res_illegal = res_illegal_q;
`else
    assign bus.res_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. A behavioural ALU answers the DUT. A
// transaction-level reference model, stepped on every falling edge, checks
// all outputs. Directed requests with literal expectations are followed by
// randomized traffic.
module tb_alu_issue_ctrl;
    localparam int DW    = 32;
    localparam int GW    = 4;
    localparam int BOUND = 20;

    typedef struct {
        logic [31:0] data;
        logic [31:0] b;
        logic [3:0]  gin;
        logic        zero;
        logic        br;
        logic        ill;
        int          lat;
    } res_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DW(DW), .GW(GW)) bus ();

    alu_issue_ctrl #(.DW(DW), .GW(GW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // External ALU behaviour: zout=1 means "branch condition met" for the branch codes
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] g);
        logic [31:0] s;
        logic        z;
        case (g)
            4'b0000:                   s = a + b;
            4'b0010, 4'b1010:          s = a - b;
            4'b1000:                   s = a & b;
            4'b0100:                   s = a | b;
            4'b1001:                   s = ~(a | b);
            4'b0001:                   s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1101, 4'b1100,
            4'b1011, 4'b1110:          s = a;
            default:                   s = 32'hDEAD_BEEF;
        endcase
        case (g)
            4'b1010: z = (s != 32'd0);
            4'b1101: z = ($signed(a) <= 0);
            4'b1100: z = ($signed(a) > 0);
            4'b1011: z = ($signed(a) >= 0);
            4'b1110: z = ($signed(a) < 0);
            default: z = (s == 32'd0);
        endcase
        return {z, s};
    endfunction

    logic [32:0] alu_out;
    assign alu_out      = alu_fn(bus.alu_a, bus.alu_b, bus.alu_gin);
    assign bus.alu_sum  = alu_out[31:0];
    assign bus.alu_zout = alu_out[32];

    // Instruction table: bsel 0 = rt_val, 1 = sign-extended imm, 2 = zero-extended imm
    function automatic void decode(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                                   output logic legal, output logic [3:0] g,
                                   output int bsel, output logic br);
        legal = 1'b1; g = 4'b0000; bsel = 0; br = 1'b0;
        case (op)
            6'b000000: case (fn)
                6'b100000: g = 4'b0000;
                6'b100010: g = 4'b0010;
                6'b100100: g = 4'b1000;
                6'b100101: g = 4'b0100;
                6'b100111: g = 4'b1001;
                6'b101010: g = 4'b0001;
                default:   legal = 1'b0;
            endcase
            6'b001000, 6'b100011, 6'b101011: bsel = 1;
            6'b001010: begin g = 4'b0001; bsel = 1; end
            6'b001100: begin g = 4'b1000; bsel = 2; end
            6'b001101: begin g = 4'b0100; bsel = 2; end
            6'b000100: begin g = 4'b0010; br = 1'b1; end
            6'b000101: begin g = 4'b1010; br = 1'b1; end
            6'b000110: begin g = 4'b1101; br = 1'b1; end
            6'b000111: begin g = 4'b1100; br = 1'b1; end
            6'b000001: begin
                if (rt == 5'd1)      begin g = 4'b1011; br = 1'b1; end
                else if (rt == 5'd0) begin g = 4'b1110; br = 1'b1; end
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin g = 4'b0000; bsel = 0; br = 1'b0; end
    endfunction

    // Reference model: expected ALU drive, the pending result, and how many
    // edges remain until the result shows up
    logic [31:0] m_a, m_b, m_data;
    logic [3:0]  m_gin;
    logic        m_zero, m_br, m_ill, m_resp;
    int          m_left;

    task automatic model_step();
        logic        legal, br;
        logic [3:0]  g;
        int          bsel;
        logic [31:0] b;
        logic [32:0] r;
        if (!reset_n) begin
            m_a = 0; m_b = 0; m_gin = 0; m_data = 0;
            m_zero = 0; m_br = 0; m_ill = 0; m_resp = 0; m_left = 0;
            chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
            chk("rst_alu_a", bus.alu_a, 32'd0);
            chk("rst_alu_b", bus.alu_b, 32'd0);
            chk("rst_alu_gin", 32'(bus.alu_gin), 32'd0);
            chk("rst_res_data", bus.res_data, 32'd0);
            chk("rst_res_flags", {29'd0, bus.res_zero, bus.res_branch, bus.res_illegal}, 32'd0);
            return;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(!m_resp && m_left == 0));
        chk("res_valid", 32'(bus.res_valid), 32'(m_resp));
        chk("alu_a", bus.alu_a, m_a);
        chk("alu_b", bus.alu_b, m_b);
        chk("alu_gin", 32'(bus.alu_gin), 32'(m_gin));
        if (m_resp) begin
            chk("res_data", bus.res_data, m_data);
            chk("res_zero", 32'(bus.res_zero), 32'(m_zero));
            chk("res_branch", 32'(bus.res_branch), 32'(m_br));
            chk("res_illegal", 32'(bus.res_illegal), 32'(m_ill));
        end
        // predict the coming rising edge
        if (m_resp) begin
            if (bus.res_ready) m_resp = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_resp = 1'b1;
        end else if (bus.req_valid) begin
            decode(bus.req_opcode, bus.req_funct, bus.req_rt, legal, g, bsel, br);
            b = (bsel == 1) ? {{16{bus.req_imm[15]}}, bus.req_imm} :
                (bsel == 2) ? {16'd0, bus.req_imm} : bus.req_rt_val;
`ifdef ALU_ISSUE_ILLEGAL_EN
            if (!legal) begin
                m_data = 0; m_zero = 0; m_br = 0; m_ill = 1; m_resp = 1'b1;
            end else
`endif
            begin
                r = alu_fn(bus.req_rs_val, b, g);
                m_a = bus.req_rs_val; m_b = b; m_gin = g;
                m_data = r[31:0]; m_zero = r[32]; m_br = br & r[32]; m_ill = 0;
                m_left = 1;
            end
        end
    endtask

    always @(negedge clk) model_step();

    task automatic scramble();
        bus.req_opcode = 6'($urandom);
        bus.req_funct  = 6'($urandom);
        bus.req_rt     = 5'($urandom);
        bus.req_imm    = 16'($urandom);
        bus.req_rs_val = $urandom;
        bus.req_rt_val = $urandom;
    endtask

    // Offer one request, wait for its result, then release it after 'stall' extra cycles
    task automatic do_req(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                          input logic [15:0] imm, input logic [31:0] rs_v, input logic [31:0] rt_v,
                          input int stall, output res_t r);
        int n;
        bus.req_valid = 1'b1;
        bus.req_opcode = op; bus.req_funct = fn; bus.req_rt = rt;
        bus.req_imm = imm; bus.req_rs_val = rs_v; bus.req_rt_val = rt_v;
        bus.res_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < BOUND);
        chk("accept_seen", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble();
        bus.res_ready = (stall == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.res_valid && n < BOUND);
        chk("resp_seen", 32'(bus.res_valid), 32'd1);
        r.data = bus.res_data; r.zero = bus.res_zero; r.br = bus.res_branch;
        r.ill = bus.res_illegal; r.b = bus.alu_b; r.gin = bus.alu_gin; r.lat = n;
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   n;
        logic [5:0]  op, fn;
        logic [4:0]  rt;
        logic [31:0] rs_v, rt_v;
        int   k;

        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // add 5 + 7
        do_req(6'b000000, 6'b100000, 5'd0, 16'd0, 32'd5, 32'd7, 0, r);
        chk("add_gin", 32'(r.gin), 32'd0);
        chk("add_b", r.b, 32'd7);
        chk("add_lat", 32'(r.lat), 32'd2);
        chk("add_data", r.data, 32'd12);
        chk("add_zero_br", {30'd0, r.zero, r.br}, 32'd0);

        // addi sign extension, ori zero extension
        do_req(6'b001000, 6'd0, 5'd0, 16'hFFFF, 32'd1, 32'd0, 1, r);
        chk("addi_b", r.b, 32'hFFFF_FFFF);
        chk("addi_data", r.data, 32'd0);
        chk("addi_zero", 32'(r.zero), 32'd1);
        do_req(6'b001101, 6'd0, 5'd0, 16'h8000, 32'd0, 32'd0, 0, r);
        chk("ori_b", r.b, 32'h0000_8000);
        chk("ori_data", r.data, 32'h0000_8000);

        // branches
        do_req(6'b000100, 6'd0, 5'd0, 16'd0, 32'd9, 32'd9, 0, r);
        chk("beq_gin", 32'(r.gin), 32'b0010);
        chk("beq_branch", 32'(r.br), 32'd1);
        do_req(6'b000101, 6'd0, 5'd0, 16'd0, 32'd3, 32'd4, 2, r);
        chk("bne_gin", 32'(r.gin), 32'b1010);
        chk("bne_taken", 32'(r.br), 32'd1);
        do_req(6'b000101, 6'd0, 5'd0, 16'd0, 32'd4, 32'd4, 0, r);
        chk("bne_not_taken", 32'(r.br), 32'd0);

        // illegal opcode
        do_req(6'b111111, 6'd0, 5'd0, 16'h1234, 32'd10, 32'd20, 0, r);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("ill_lat", 32'(r.lat), 32'd1);
        chk("ill_flag", 32'(r.ill), 32'd1);
        chk("ill_data", r.data, 32'd0);
        chk("ill_gin_kept", 32'(r.gin), 32'b1010);
`else
        chk("ill_gin", 32'(r.gin), 32'd0);
        chk("ill_data", r.data, 32'd30);
        chk("ill_flag", 32'(r.ill), 32'd0);
        chk("ill_lat", 32'(r.lat), 32'd2);
`endif

        // backpressure: result held 5 cycles while a second request waits
        bus.req_valid = 1'b1; bus.req_opcode = 6'b000000; bus.req_funct = 6'b100000;
        bus.req_rs_val = 32'd100; bus.req_rt_val = 32'd23; bus.res_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < BOUND);
        chk("bp_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_funct = 6'b100010; bus.req_rs_val = 32'd50; bus.req_rt_val = 32'd8;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.res_valid && n < BOUND);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_data", bus.res_data, 32'd123);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble();
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.res_valid && n < BOUND);
        chk("bp_second_data", bus.res_data, 32'd42);
        @(posedge clk); #1;
        bus.res_ready = 1'b0;

        // reset in the middle of EXEC
        bus.req_valid = 1'b1; bus.req_opcode = 6'b000000; bus.req_funct = 6'b100010;
        bus.req_rs_val = 32'd8; bus.req_rt_val = 32'd3;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < BOUND);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("exec_gin_before_reset", 32'(bus.alu_gin), 32'b0010);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_gin", 32'(bus.alu_gin), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        do_req(6'b000000, 6'b100000, 5'd0, 16'd0, 32'd5, 32'd7, 0, r);
        chk("post_rst_data", r.data, 32'd12);
        chk("post_rst_lat", 32'(r.lat), 32'd2);

        // randomized traffic, checked by the reference model
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 19);
            fn = 6'($urandom); rt = 5'($urandom);
            case (k)
                0: begin op = 6'b000000; fn = 6'b100000; end
                1: begin op = 6'b000000; fn = 6'b100010; end
                2: begin op = 6'b000000; fn = 6'b100100; end
                3: begin op = 6'b000000; fn = 6'b100101; end
                4: begin op = 6'b000000; fn = 6'b100111; end
                5: begin op = 6'b000000; fn = 6'b101010; end
                6: op = 6'b001000;
                7: op = 6'b001010;
                8: op = 6'b100011;
                9: op = 6'b101011;
                10: op = 6'b001100;
                11: op = 6'b001101;
                12: op = 6'b000100;
                13: op = 6'b000101;
                14: op = 6'b000110;
                15: op = 6'b000111;
                16: begin op = 6'b000001; rt = 5'd1; end
                17: begin op = 6'b000001; rt = 5'd0; end
                18: op = 6'($urandom);
                default: op = 6'b000000;
            endcase
            case ($urandom_range(0, 3))
                0: rs_v = 32'd0;
                1: rs_v = 32'h8000_0000 + 32'($urandom_range(0, 3));
                default: rs_v = $urandom;
            endcase
            rt_v = ($urandom_range(0, 3) == 0) ? rs_v : $urandom;
            do_req(op, fn, rt, 16'($urandom), rs_v, rt_v, $urandom_range(0, 3), r);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; scramble(); end
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 32-bit ALU interface (a, b, 4-bit gin in; sum, zout back).
- Accepts decoded MIPS-lite instruction fields and register operands over a valid/ready handshake.
- Generates the ALU control-line code and the b operand, then drives the external ALU.
- Captures sum/zout one cycle later and returns the result and branch decision over a second valid/ready handshake.

Parameters:
- DW, 32, datapath width; must match the ALU.
- GW, 4, ALU control-line width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_opcode  in  6  instr[31:26].
- req_funct  in  6  instr[5:0]; used when opcode=000000.
- req_rt  in  5  instr[20:16]; used when opcode=000001.
- req_imm  in  16  instr[15:0].
- req_rs_val  in  DW  rs register value.
- req_rt_val  in  DW  rt register value.
- alu_a  out  DW  registered ALU a operand.
- alu_b  out  DW  registered ALU b operand.
- alu_gin  out  GW  registered ALU control line.
- alu_sum  in  DW  ALU result; combinational from alu_a/alu_b/alu_gin.
- alu_zout  in  1  ALU zero flag.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DW  captured alu_sum.
- res_zero  out  1  captured alu_zout.
- res_branch  out  1  branch instruction whose condition is met.
- res_illegal  out  1  unsupported encoding (see Optional Feature).

Behaviour:
- Reset: state=IDLE. All outputs are 0 except req_ready=1. Reset is honoured mid-operation: any in-flight request is dropped and res_valid drops immediately.
- States: IDLE, EXEC, RESP. req_ready=1 only in IDLE. Maximum throughput is one request per 3 cycles.
- IDLE: on req_valid&req_ready, register alu_a/alu_b/alu_gin and an is_branch flag, then go to EXEC.
- EXEC: outputs are stable for one cycle. At the next edge, capture alu_sum→res_data and alu_zout→res_zero. Set res_branch=is_branch&alu_zout. Go to RESP.
- RESP: res_valid=1 and the result fields are held stable. When res_ready=1, go to IDLE on that edge and deassert res_valid. Latency from accept to res_valid is 2 cycles.
- alu_a is always rs_val.
- Decode to gin and b (SE = sign-extended imm, ZE = zero-extended imm):
  - R-type (opcode 000000), b=rt_val: funct 100000 add→0000; 100010 sub→0010; 100100 and→1000; 100101 or→0100; 100111 nor→1001; 101010 slt→0001.
  - addi 001000→0000, b=SE. slti 001010→0001, b=SE. lw 100011→0000, b=SE. sw 101011→0000, b=SE.
  - andi 001100→1000, b=ZE. ori 001101→0100, b=ZE.
  - Branches (is_branch=1), b=rt_val: beq 000100→0010; bne 000101→1010; blez 000110→1101; bgtz 000111→1100. opcode 000001: rt=00001 bgez→1011; rt=00000 bltz→1110.
  - Branch taken is always alu_zout=1.
- Any other encoding is illegal.
- alu_gin never carries an undefined code. Illegal requests drive gin=0000.
- Inputs are sampled only at the accept edge. Changes on request inputs at any other time have no effect.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_EN.
- Defined: an illegal request skips EXEC (IDLE→RESP directly, 1-cycle latency). It returns res_data=0, res_zero=0, res_branch=0, res_illegal=1. alu_a/alu_b/alu_gin keep their previous values.
- Undefined: an illegal request is executed as add with b=rt_val through the normal 2-cycle path. res_illegal is tied to 0.

Test Plan:
- Reset mid-EXEC: assert reset_n=0 → res_valid=0, req_ready=1, alu_gin=0 immediately. After release, a new request completes normally.
- add: rs=5, rt=7, funct 100000 → alu_gin=0000, alu_b=7, res_valid 2 cycles after accept, res_data=12, res_zero=0, res_branch=0.
- addi/ori extension: addi rs=1, imm=FFFF → alu_b=FFFFFFFF, res_data=0, res_zero=1. ori rs=0, imm=8000 → alu_b=00008000.
- beq/bne: beq rs=rt=9 → gin=0010, res_branch=1. bne rs=3, rt=4 → gin=1010, res_branch=1. bne rs=rt=4 → res_branch=0.
- Backpressure: hold res_ready=0 for 5 cycles → res_valid and res_data stable, req_ready=0, a second req_valid is not accepted. res_ready=1 → IDLE next cycle, then the second request is accepted.
- Illegal opcode 111111:
  - With ALU_ISSUE_ILLEGAL_EN: res_valid 1 cycle after accept, res_illegal=1, res_data=0.
  - Without: gin=0000, res_data=rs+rt, res_illegal=0.
